// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared types and defaults for the instruction fetch stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  localparam int unsigned ADDR_W_DEF = 64;
  localparam int unsigned INST_W_DEF = 32;
  localparam int unsigned PC_STEP    = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DROP = 2'd3
  } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/fetch_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_if
//  Description : Redirect, instruction-memory and decode-side signals of the
//                fetch stage. master = fetch unit, slave = its environment.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_if
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned INST_W = INST_W_DEF
) ();

  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [INST_W-1:0] imem_rdata;
  logic              inst_valid;
  logic              inst_ready;
  logic [INST_W-1:0] inst_data;
  logic [ADDR_W-1:0] inst_pc;

  modport master (
    input  redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
    output imem_req, imem_addr, inst_valid, inst_data, inst_pc
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
    input  imem_req, imem_addr, inst_valid, inst_data, inst_pc
  );

endinterface
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue
//  Description : Synchronous FIFO holding fetched {pc, inst} pairs. Supports
//                simultaneous push/pop (also when full) and a one-cycle flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned WIDTH = ADDR_W_DEF + INST_W_DEF,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [WIDTH-1:0]           head_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q;
  logic [PTR_W-1:0] rd_q;
  logic [CNT_W-1:0] count_q;
  logic             w_pop;
  logic             w_push;

  // Pop on empty is ignored; push on full is only legal alongside a pop.
  assign w_pop  = pop_i && (count_q != '0);
  assign w_push = push_i && ((count_q != CNT_W'(DEPTH)) || w_pop);

  // Pointer and occupancy update; flush empties the queue in one cycle.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (w_push) wr_q <= wr_q + 1'b1;
      if (w_pop)  rd_q <= rd_q + 1'b1;
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge CLK) begin
    if (w_push && !flush_i) mem_q[wr_q] <= data_i;
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_q];

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction fetch stage. Owns the fetch PC, issues one
//                outstanding request at a time to instruction memory, queues
//                {pc, inst} pairs for decode and handles branch redirects.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = ADDR_W_DEF,
  parameter int unsigned       INST_W   = INST_W_DEF,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic     CLK,
  input  logic     reset,
  fetch_if.master  bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned Q_W   = ADDR_W + INST_W;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] pc_of_req_q, pc_of_req_d;

  logic [CNT_W-1:0]  w_count;
  logic [Q_W-1:0]    w_head;
  logic              w_valid;
  logic              w_push;
  logic              w_pop;
  logic [CNT_W:0]    w_occupied;
  logic [CNT_W:0]    w_after_push;
  logic              w_space;
  logic              w_space_after;
  logic [ADDR_W-1:0] w_redirect_pc;

  assign w_valid       = (w_count != '0);
  assign w_pop         = w_valid && bus.inst_ready;
  // A response racing a redirect belongs to the old path and is discarded.
  assign w_push        = (state_q == ST_WAIT) && bus.imem_rvalid && !bus.redirect_valid;
  assign w_redirect_pc = bus.redirect_pc & ~(ADDR_W'(3));

  // The outstanding request reserves a queue slot so a push can never overflow.
  assign w_occupied    = {1'b0, w_count} + (CNT_W + 1)'(state_q == ST_WAIT);
  assign w_space       = w_occupied < (CNT_W + 1)'(DEPTH);
  assign w_after_push  = {1'b0, w_count} + (CNT_W + 1)'(1) - (CNT_W + 1)'(w_pop);
  assign w_space_after = w_after_push < (CNT_W + 1)'(DEPTH);

  fetch_queue #(
    .WIDTH (Q_W),
    .DEPTH (DEPTH)
  ) u_queue (
    .CLK     (CLK),
    .reset   (reset),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .flush_i (bus.redirect_valid),
    .data_i  ({pc_of_req_q, bus.imem_rdata}),
    .count_o (w_count),
    .head_o  (w_head)
  );

  // State, fetch PC and the PC of the in-flight request.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      fetch_pc_q  <= RESET_PC;
      pc_of_req_q <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      pc_of_req_q <= pc_of_req_d;
    end
  end

  // Next-state logic; a redirect overrides the normal transition in any state.
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    pc_of_req_d = pc_of_req_q;

    case (state_q)
      ST_IDLE: if (w_space) state_d = ST_REQ;
      ST_REQ: begin
        if (bus.imem_gnt) begin
          state_d     = ST_WAIT;
          pc_of_req_d = fetch_pc_q;
          fetch_pc_d  = fetch_pc_q + ADDR_W'(PC_STEP);
        end
      end
      ST_WAIT: if (bus.imem_rvalid) state_d = w_space_after ? ST_REQ : ST_IDLE;
      ST_DROP: if (bus.imem_rvalid) state_d = ST_REQ;
      default: state_d = ST_IDLE;
    endcase

    if (bus.redirect_valid) begin
      fetch_pc_d = w_redirect_pc;
      case (state_q)
        // A granted request still owes a response that must be swallowed.
        ST_REQ:  state_d = bus.imem_gnt ? ST_DROP : ST_REQ;
        ST_WAIT: state_d = bus.imem_rvalid ? ST_REQ : ST_DROP;
        // Keep dropping unless the awaited response lands this very cycle.
        ST_DROP: state_d = bus.imem_rvalid ? ST_REQ : ST_DROP;
        default: state_d = ST_REQ;
      endcase
    end
  end

  assign bus.imem_req   = (state_q == ST_REQ);
  assign bus.imem_addr  = fetch_pc_q;
  assign bus.inst_valid = w_valid;
  assign bus.inst_data  = w_valid ? w_head[INST_W-1:0] : '0;
  assign bus.inst_pc    = w_valid ? w_head[Q_W-1:INST_W] : '0;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Directed testbench for fetch_unit with a scoreboard of
//                expected {pc, inst} pairs drained by an output monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  fetch_if #(.ADDR_W(64), .INST_W(32)) bus ();

  fetch_unit #(
    .ADDR_W   (64),
    .INST_W   (32),
    .DEPTH    (4),
    .RESET_PC (64'h100)
  ) dut (
    .CLK   (clk),
    .reset (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [63:0] pc;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One request/response pair: grant on the pending request, data next cycle.
  task automatic fetch_one(input logic [63:0] addr, input bit expect_push);
    int w;
    w = 0;
    while (!bus.imem_req && w < 20) begin
      step();
      w++;
    end
    if (!bus.imem_req) begin
      n_vec++;
      n_err++;
      $display("FAIL req_timeout: imem_req stayed 0, expected request for %h", addr);
      return;
    end
    chk("imem_addr", bus.imem_addr, addr);
    bus.imem_gnt = 1'b1;
    step();
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = mem_word(addr);
    if (expect_push) exp_q.push_back('{addr, mem_word(addr)});
    step();
    bus.imem_rvalid = 1'b0;
  endtask

  // Output monitor: every decode handshake must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && bus.inst_valid && bus.inst_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_inst: got pc %h data %h, expected nothing", bus.inst_pc, bus.inst_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("inst_pc", bus.inst_pc, mon_e.pc);
        chk("inst_data", {32'b0, bus.inst_data}, {32'b0, mon_e.data});
      end
    end
  end

  initial begin
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.imem_gnt       = 1'b0;
    bus.imem_rvalid    = 1'b0;
    bus.imem_rdata     = '0;
    bus.inst_ready     = 1'b1;

    // ---- 1: reset values, then in-order fetch from RESET_PC ----
    step();
    step();
    chk("rst_req", {63'b0, bus.imem_req}, 64'h0);
    chk("rst_valid", {63'b0, bus.inst_valid}, 64'h0);
    chk("rst_addr", bus.imem_addr, 64'h100);
    chk("rst_inst_pc", bus.inst_pc, 64'h0);
    chk("rst_inst_data", {32'b0, bus.inst_data}, 64'h0);
    rst = 1'b0;
    step();
    chk("req_cycle1", {63'b0, bus.imem_req}, 64'h1);
    fetch_one(64'h100, 1'b1);
    chk("lat_valid", {63'b0, bus.inst_valid}, 64'h1);
    chk("lat_pc", bus.inst_pc, 64'h100);
    fetch_one(64'h104, 1'b1);
    fetch_one(64'h108, 1'b1);
    step();
    step();
    chk("t1_drained", 64'(exp_q.size()), 64'h0);

    // ---- 2: decode stalled, queue fills to DEPTH ----
    bus.inst_ready = 1'b0;
    fetch_one(64'h10C, 1'b1);
    fetch_one(64'h110, 1'b1);
    fetch_one(64'h114, 1'b1);
    fetch_one(64'h118, 1'b1);
    chk("full_req", {63'b0, bus.imem_req}, 64'h0);
    step();
    step();
    step();
    chk("full_req_hold", {63'b0, bus.imem_req}, 64'h0);
    chk("full_valid", {63'b0, bus.inst_valid}, 64'h1);
    chk("full_head_pc", bus.inst_pc, 64'h10C);
    bus.inst_ready = 1'b1;
    step();
    bus.inst_ready = 1'b0;
    chk("pop1_req", {63'b0, bus.imem_req}, 64'h0);
    step();
    chk("refill_req", {63'b0, bus.imem_req}, 64'h1);
    chk("refill_addr", bus.imem_addr, 64'h11C);
    fetch_one(64'h11C, 1'b1);
    chk("refull_req", {63'b0, bus.imem_req}, 64'h0);
    bus.inst_ready = 1'b1;
    for (int i = 0; i < 8; i++) step();
    chk("t2_drained", 64'(exp_q.size()), 64'h0);

    // ---- 3: redirect while waiting, with one entry queued ----
    bus.inst_ready = 1'b0;
    fetch_one(64'h120, 1'b0);
    chk("t3_addr", bus.imem_addr, 64'h124);
    bus.imem_gnt = 1'b1;
    step();
    bus.imem_gnt       = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h2003;
    step();
    bus.redirect_valid = 1'b0;
    chk("t3_flush_valid", {63'b0, bus.inst_valid}, 64'h0);
    chk("t3_drop_req", {63'b0, bus.imem_req}, 64'h0);
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hDEADBEEF;
    step();
    bus.imem_rvalid = 1'b0;
    chk("t3_req", {63'b0, bus.imem_req}, 64'h1);
    chk("t3_redir_addr", bus.imem_addr, 64'h2000);
    chk("t3_valid", {63'b0, bus.inst_valid}, 64'h0);
    bus.inst_ready = 1'b1;
    fetch_one(64'h2000, 1'b1);

    // ---- 4: redirect in the same cycle as rvalid ----
    chk("t4_addr", bus.imem_addr, 64'h2004);
    bus.imem_gnt = 1'b1;
    step();
    bus.imem_gnt       = 1'b0;
    bus.imem_rvalid    = 1'b1;
    bus.imem_rdata     = mem_word(64'h2004);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h3000;
    step();
    bus.imem_rvalid    = 1'b0;
    bus.redirect_valid = 1'b0;
    chk("t4_req", {63'b0, bus.imem_req}, 64'h1);
    chk("t4_addr_new", bus.imem_addr, 64'h3000);
    chk("t4_no_push", {63'b0, bus.inst_valid}, 64'h0);

    // ---- 5: redirect in REQ without grant ----
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h4000;
    step();
    bus.redirect_valid = 1'b0;
    chk("t5_req", {63'b0, bus.imem_req}, 64'h1);
    chk("t5_addr", bus.imem_addr, 64'h4000);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_hold_req", {63'b0, bus.imem_req}, 64'h1);
      chk("t5_hold_addr", bus.imem_addr, 64'h4000);
    end
    fetch_one(64'h4000, 1'b1);
    step();

    // ---- 6: reset during WAIT with two queued entries ----
    bus.inst_ready = 1'b0;
    fetch_one(64'h4004, 1'b0);
    fetch_one(64'h4008, 1'b0);
    chk("t6_addr", bus.imem_addr, 64'h400C);
    bus.imem_gnt = 1'b1;
    step();
    bus.imem_gnt = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", {63'b0, bus.inst_valid}, 64'h0);
    chk("t6_rst_req", {63'b0, bus.imem_req}, 64'h0);
    chk("t6_rst_addr", bus.imem_addr, 64'h100);
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h12345678;
    step();
    rst = 1'b0;
    step();
    bus.imem_rvalid = 1'b0;
    chk("t6_late_ignored", {63'b0, bus.inst_valid}, 64'h0);
    chk("t6_req", {63'b0, bus.imem_req}, 64'h1);
    chk("t6_refetch", bus.imem_addr, 64'h100);
    bus.inst_ready = 1'b1;
    fetch_one(64'h100, 1'b1);
    for (int i = 0; i < 4; i++) step();
    chk("final_drained", 64'(exp_q.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
